// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg -- definitions shared by the UART boot loader and its receiver.
//   * loader state encoding (CHK exists only with BOOT_CHECKSUM_EN defined)
//   * UART receiver bit-FSM encoding
//   * CLKS_PER_BIT derivation and image-format constants
//   * checksum accumulate helper
// ---------------------------------------------------------------------------
package boot_pkg;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    CHK   = 3'd3,
`endif
    DONE  = 3'd4,
    ERROR = 3'd5
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Image layout: 2-byte word count, then 4 bytes per word.
  localparam int COUNT_BYTES    = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Running XOR checksum over the data bytes.
  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if -- instruction-memory write port.
//   imem_we    : one-cycle write strobe
//   imem_addr  : byte address of the word (multiple of 4)
//   imem_wdata : word being written
// master = loader (drives), slave = instruction memory (receives).
// ---------------------------------------------------------------------------
interface boot_loader_if #(
  parameter int PC_WIDTH  = 16,
  parameter int OP_LENGTH = 32
);
  logic                 imem_we;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic [OP_LENGTH-1:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/boot_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx            : serial line, idle high, asynchronous to clk
//   rx_data       : received byte, valid with rx_valid
//   rx_valid      : one-cycle pulse at the stop-bit centre (good stop bit)
//   rx_frame_err  : one-cycle pulse at the stop-bit centre (stop bit low)
// ---------------------------------------------------------------------------
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_r;
  logic          prev_r;
  logic          rx_s;
  rx_state_e     state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], rx};
      prev_r <= rx_s;
    end
  end

  // Bit FSM: start detect, half-bit re-check, centre sampling, stop check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RX_IDLE;
      cnt_r        <= {CW{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (prev_r && !rx_s) begin
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            // A line that is high again at half-bit was a glitch.
            state_r   <= rx_s ? RX_IDLE : RX_BITS;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        RX_BITS: begin
          if (cnt_r == FULL_M1) begin
            cnt_r     <= {CW{1'b0}};
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= RX_IDLE;
            if (rx_s) begin
              rx_data  <= shift_r;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader -- UART boot loader in front of the CPU. Receives a 16-bit LE
// word count N followed by N little-endian 32-bit words, writes them to
// instruction memory from address 0 upward, then releases the CPU.
// Optional feature macro: BOOT_CHECKSUM_EN -- expects one trailing byte equal
// to the XOR of all data bytes; a mismatch ends in ERROR.
// Ports:
//   sysclk   : system clock
//   rst      : asynchronous active-low reset
//   uart_rx  : serial input (8N1, idle high)
//   imem     : instruction-memory write port (boot_loader_if.master)
//   cpu_rst  : active-high CPU reset, low once the load has completed
//   busy     : load in progress
//   done     : image loaded, sticky
//   err      : load failed, sticky
// ---------------------------------------------------------------------------
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int OP_LENGTH = 32,
  parameter int PC_WIDTH  = 16
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          uart_rx,
  boot_loader_if.master imem,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  // Largest legal word count: fills the byte-address space exactly.
  localparam logic [16:0] MAX_WORDS = 17'd1 << (PC_WIDTH - 2);

  logic [7:0]  rx_data_s;
  logic        rx_valid_s;
  logic        rx_frame_err_s;
  logic [15:0] len_s;
  logic [15:0] word_next_s;

  boot_state_e state_r;
  logic [7:0]  len_lo_r;
  logic [15:0] n_words_r;
  logic [15:0] word_cnt_r;
  logic [1:0]  byte_idx_r;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  xor_r;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk          (sysclk),
    .rst_n        (rst),
    .rx           (uart_rx),
    .rx_data      (rx_data_s),
    .rx_valid     (rx_valid_s),
    .rx_frame_err (rx_frame_err_s)
  );

  assign len_s       = {rx_data_s, len_lo_r};
  assign word_next_s = word_cnt_r + 16'd1;

  // Loader FSM with byte assembly, address/word counters and registered outputs.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_r         <= LEN0;
      len_lo_r        <= 8'd0;
      n_words_r       <= 16'd0;
      word_cnt_r      <= 16'd0;
      byte_idx_r      <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
      xor_r           <= 8'd0;
`endif
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= {PC_WIDTH{1'b0}};
      imem.imem_wdata <= {OP_LENGTH{1'b0}};
      cpu_rst         <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      imem.imem_we <= 1'b0;
      case (state_r)
        LEN0: begin
          if (rx_frame_err_s) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (rx_valid_s) begin
            len_lo_r <= rx_data_s;
            busy     <= 1'b1;
            state_r  <= LEN1;
          end
        end
        LEN1: begin
          if (rx_frame_err_s) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (rx_valid_s) begin
            n_words_r <= len_s;
            if (len_s == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state_r <= CHK;
`else
              state_r <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b0;
`endif
            end else if ({1'b0, len_s} > MAX_WORDS) begin
              state_r <= ERROR;
              err     <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (imem.imem_we) begin
            // Write cycle: advance counters. The address is not bumped past
            // the final word so that it never wraps.
            word_cnt_r <= word_next_s;
            if (word_next_s == n_words_r) begin
`ifdef BOOT_CHECKSUM_EN
              state_r <= CHK;
`else
              state_r <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b0;
`endif
            end else begin
              imem.imem_addr <= imem.imem_addr + PC_WIDTH'(4);
            end
          end else if (rx_frame_err_s) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (rx_valid_s) begin
            imem.imem_wdata[{byte_idx_r, 3'b000} +: 8] <= rx_data_s;
`ifdef BOOT_CHECKSUM_EN
            xor_r <= xor_acc(xor_r, rx_data_s);
`endif
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'(BYTES_PER_WORD - 1)) begin
              imem.imem_we <= 1'b1;
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK: begin
          if (rx_frame_err_s) begin
            state_r <= ERROR;
            err     <= 1'b1;
            busy    <= 1'b0;
          end else if (rx_valid_s) begin
            if (rx_data_s == xor_r) begin
              state_r <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b0;
            end else begin
              state_r <= ERROR;
              err     <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
`endif
        DONE: begin
          state_r <= DONE;
        end
        ERROR: begin
          state_r <= ERROR;
        end
        default: begin
          state_r <= ERROR;
          err     <= 1'b1;
          busy    <= 1'b0;
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader -- directed bench for boot_loader at 100 clocks per bit.
// Expected memory writes are queued as images are sent; a monitor records
// every imem_we cycle and the two streams are compared after each load.
// Builds with or without BOOT_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_boot_loader;

  localparam int CPB = 100;

  logic sysclk  = 1'b0;
  logic rst     = 1'b0;
  logic uart_rx = 1'b1;
  logic cpu_rst;
  logic busy;
  logic done;
  logic err;

  int vectors     = 0;
  int miscompares = 0;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int          rd_idx = 0;

  boot_loader_if #(.PC_WIDTH(16), .OP_LENGTH(32)) mem_if ();

  boot_loader #(
    .CLK_FREQ  (100000000),
    .BAUD      (1000000),
    .OP_LENGTH (32),
    .PC_WIDTH  (16)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .imem    (mem_if.master),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 sysclk = ~sysclk;

  // Record every cycle in which the write strobe is high.
  always @(negedge sysclk) begin
    if (mem_if.imem_we === 1'b1) begin
      obs_q.push_back({mem_if.imem_addr, mem_if.imem_wdata});
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cpu_rst, busy, done, err}
  task automatic check_status(input string tag, input logic [3:0] exp);
    check(tag, {44'd0, cpu_rst, busy, done, err}, {44'd0, exp});
  endtask

  task automatic expect_write(input logic [15:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic check_writes(input string tag);
    check({tag, " count"}, 48'(obs_q.size() - rd_idx), 48'(exp_q.size()));
    while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
      check(tag, obs_q[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge sysclk);
    check_status({tag, " reset status"}, 4'b1000);
    check({tag, " reset bus"}, {mem_if.imem_we, 15'd0, mem_if.imem_addr, mem_if.imem_wdata} >> 15,
          48'd0);
    rd_idx = obs_q.size();
    rst = 1'b1;
    repeat (5) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge sysclk);
    uart_rx = 1'b1;
  endtask

  // Bounded wait for the load to finish either way.
  task automatic wait_end();
    for (int i = 0; i < 20 * CPB && !(done || err); i++) @(negedge sysclk);
    repeat (5) @(negedge sysclk);
  endtask

  initial begin
    // Scenario 1: two-word image, then a stray byte after DONE.
    do_reset("s1");
    expect_write(16'h0000, 32'h0000_0013);
    expect_write(16'h0004, 32'h0000_006F);
    send_byte(8'h02);
    check_status("s1 busy after first byte", 4'b1100);
    send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h7C);
`endif
    wait_end();
    check_status("s1 done", 4'b0010);
    check_writes("s1 writes");
    send_byte(8'h55);
    repeat (20) @(negedge sysclk);
    check_status("s1 after extra byte", 4'b0010);
    check_writes("s1 extra writes");

    // Scenario 2: a false start glitch, then a zero-length image.
    do_reset("s2");
    uart_rx = 1'b0;
    repeat (20) @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge sysclk);
    check_status("s2 glitch ignored", 4'b1000);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end();
    check_status("s2 done", 4'b0010);
    check_writes("s2 writes");

    // Scenario 3: largest legal count is accepted, one more is rejected.
    do_reset("s3a");
    send_byte(8'h00);
    send_byte(8'h40);
    repeat (20) @(negedge sysclk);
    check_status("s3 N=16384 accepted", 4'b1100);
    do_reset("s3b");
    send_byte(8'h01);
    send_byte(8'h40);
    wait_end();
    check_status("s3 N=16385 error", 4'b1001);
    send_byte(8'h13);
    repeat (20) @(negedge sysclk);
    check_status("s3 error sticky", 4'b1001);
    check_writes("s3 writes");

`ifdef BOOT_CHECKSUM_EN
    // Scenario 4: bad checksum after two good writes.
    do_reset("s4");
    expect_write(16'h0000, 32'h0000_0013);
    expect_write(16'h0004, 32'h0000_006F);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h7D);
    wait_end();
    check_status("s4 checksum error", 4'b1001);
    check_writes("s4 writes");
`endif

    // Scenario 5: framing error on the third data byte.
    do_reset("s5");
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00);
    send_byte(8'h00, 1'b0);
    wait_end();
    check_status("s5 framing error", 4'b1001);
    send_byte(8'h00);
    send_byte(8'h6F);
    repeat (20) @(negedge sysclk);
    check_status("s5 error sticky", 4'b1001);
    check_writes("s5 writes");

    // Scenario 6: reset mid-word, then a fresh image loads from address 0.
    do_reset("s6a");
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    do_reset("s6b");
    expect_write(16'h0000, 32'h1234_5678);
    expect_write(16'h0004, 32'hDEAD_BEEF);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h2A);
`endif
    wait_end();
    check_status("s6 done", 4'b0010);
    check_writes("s6 writes");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
